// File: rtl/cia_icr_if.sv
// cia_icr_if: CPU register-access bundle for the CIA interrupt control register.
//   wr        write strobe (0 = read)
//   icrs      ICR register select
//   data_in   CPU write data
//   data_out  read data from the ICR
// Modports: master = CPU side, slave = register side.
interface cia_icr_if;
    logic       wr;
    logic       icrs;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output wr,
        output icrs,
        output data_in,
        input  data_out
    );

    modport slave (
        input  wr,
        input  icrs,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/cia_icr.sv
// cia_icr: CIA interrupt control register.
// Latches timer A/B, TOD alarm, serial and /FLAG events, gates them through the
// CPU-programmed mask and raises irq. Ending a read access clears pending events.
//
// Ports:
//   clk      system clock
//   reset    synchronous reset, active-high
//   clk7_en  7MHz enable; state only updates when high
//   bus      CPU access (wr, icrs, data_in, data_out)
//   ta, tb   timer A / timer B underflow pulses
//   alrm     TOD alarm pulse
//   ser      serial byte-complete pulse
//   flag     raw /FLAG pin, active-low
//   irq      interrupt request, active-high
//
// Build option: CIA_ICR_IRQ_DELAY_EN registers irq and read bit 7 for one extra
// enabled cycle of latency (8520 timing). Undefined: irq is combinational.
module cia_icr (
    input  logic      clk,
    input  logic      reset,
    input  logic      clk7_en,
    cia_icr_if.slave  bus,
    input  logic      ta,
    input  logic      tb,
    input  logic      alrm,
    input  logic      ser,
    input  logic      flag,
    output logic      irq
);

    logic [4:0] icr_q, icr_d;
    logic [4:0] imr_q, imr_d;
    logic       flag_d_q;
    logic       rd_d_q;

    logic       rd_sel;
    logic       wr_sel;
    logic       rd_clear;
    logic [4:0] events;
    logic       irq_int;
    logic       unused_data;

    assign rd_sel   = bus.icrs & ~bus.wr;
    assign wr_sel   = bus.icrs & bus.wr;
    // Clear once the read access has ended, so the value stays stable while it lasts.
    assign rd_clear = rd_d_q & ~rd_sel;
    assign events   = {flag_d_q & ~flag, ser, alrm, tb, ta};

    // Mask write bits 6:5 carry no meaning.
    assign unused_data = ^bus.data_in[6:5];

    always_comb begin
        // New events win over the read-clear in the same cycle.
        icr_d = rd_clear ? events : (icr_q | events);
        imr_d = imr_q;
        if (wr_sel) begin
            if (bus.data_in[7]) begin
                imr_d = imr_q | bus.data_in[4:0];
            end else begin
                imr_d = imr_q & ~bus.data_in[4:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            icr_q    <= 5'd0;
            imr_q    <= 5'd0;
            flag_d_q <= 1'b1;
            rd_d_q   <= 1'b0;
        end else if (clk7_en) begin
            icr_q    <= icr_d;
            imr_q    <= imr_d;
            flag_d_q <= flag;
            rd_d_q   <= rd_sel;
        end
    end

`ifdef CIA_ICR_IRQ_DELAY_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (clk7_en) begin
            irq_q <= rd_clear ? 1'b0 : |(icr_q & imr_q);
        end
    end

    assign irq_int = irq_q;
`else
    assign irq_int = |(icr_q & imr_q);
`endif

    assign irq          = irq_int;
    assign bus.data_out = rd_sel ? {irq_int, 2'b00, icr_q} : 8'h00;

endmodule

// File: tb/tb_cia_icr.sv
// tb_cia_icr: directed self-checking bench for cia_icr with a scoreboard queue of
// expected values. Works for both builds; irq latency follows CIA_ICR_IRQ_DELAY_EN.
module tb_cia_icr;

`ifdef CIA_ICR_IRQ_DELAY_EN
    localparam logic DLY = 1'b1;
`else
    localparam logic DLY = 1'b0;
`endif

    logic clk;
    logic reset;
    logic clk7_en;
    logic ta, tb, alrm, ser, flag;
    logic irq;

    cia_icr_if bus ();

    cia_icr dut (
        .clk     (clk),
        .reset   (reset),
        .clk7_en (clk7_en),
        .bus     (bus),
        .ta      (ta),
        .tb      (tb),
        .alrm    (alrm),
        .ser     (ser),
        .flag    (flag),
        .irq     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic compare(input logic [7:0] obs);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk_dout(input string tag, input logic [7:0] exp);
        push_exp(tag, exp);
        #1;
        compare(bus.data_out);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        push_exp(tag, {7'd0, exp});
        #1;
        compare({7'd0, irq});
    endtask

    task automatic write_icr(input logic [7:0] d);
        bus.icrs    = 1'b1;
        bus.wr      = 1'b1;
        bus.data_in = d;
        cycle();
        bus.icrs    = 1'b0;
        bus.wr      = 1'b0;
        bus.data_in = 8'h00;
    endtask

    // Look at the register without letting a clock edge see the access.
    task automatic read_peek(input string tag, input logic [7:0] exp);
        bus.icrs = 1'b1;
        bus.wr   = 1'b0;
        chk_dout(tag, exp);
        bus.icrs = 1'b0;
    endtask

    // Full access: one enabled cycle of read, then the clearing cycle.
    task automatic read_clear(input string tag, input logic [7:0] exp);
        bus.icrs = 1'b1;
        bus.wr   = 1'b0;
        chk_dout(tag, exp);
        cycle();
        bus.icrs = 1'b0;
        cycle();
    endtask

    initial begin
        reset       = 1'b1;
        clk7_en     = 1'b1;
        bus.wr      = 1'b0;
        bus.icrs    = 1'b0;
        bus.data_in = 8'h00;
        ta = 1'b0; tb = 1'b0; alrm = 1'b0; ser = 1'b0; flag = 1'b1;
        cycle(2);
        reset = 1'b0;

        // Reset state
        chk_irq("rst_irq", 1'b0);
        chk_dout("idle_dout", 8'h00);
        read_clear("rst_read", 8'h00);
        write_icr(8'h00);

        // Timer B masked in, event, read and clear
        write_icr(8'h82);
        tb = 1'b1; cycle(); tb = 1'b0;
        chk_irq("tb_irq_first", ~DLY);
        cycle();
        chk_irq("tb_irq", 1'b1);
        read_clear("tb_read", 8'h82);
        chk_irq("tb_clr_irq", 1'b0);
        read_clear("tb_reread", 8'h00);

        // No update while clk7_en is low
        clk7_en = 1'b0;
        tb = 1'b1; cycle(); tb = 1'b0;
        clk7_en = 1'b1;
        chk_irq("gated_irq", 1'b0);
        read_peek("gated_read", 8'h00);

        // Unmasked event latches without irq; later mask set/clear
        write_icr(8'h00);
        ta = 1'b1; cycle(); ta = 1'b0;
        chk_irq("ta_nomask_irq", 1'b0);
        cycle();
        chk_irq("ta_nomask_irq2", 1'b0);
        read_peek("ta_nomask_read", 8'h01);
        write_icr(8'h81);
        chk_irq("mask_set_first", ~DLY);
        cycle();
        chk_irq("mask_set_irq", 1'b1);
        read_peek("mask_set_read", 8'h81);
        write_icr(8'h01);
        chk_irq("mask_clr_first", DLY);
        cycle();
        chk_irq("mask_clr_irq", 1'b0);
        read_clear("mask_clr_read", 8'h01);

        // /FLAG falling edge sets icr[4] once; held low does not re-set it
        flag = 1'b0; cycle(10); flag = 1'b1; cycle();
        read_clear("flag_read", 8'h10);
        read_peek("flag_after", 8'h00);
        flag = 1'b0; cycle(2);
        read_clear("flag_low_read", 8'h10);
        cycle(3);
        read_clear("flag_held_read", 8'h00);
        flag = 1'b1; cycle();

        // Event in the read-clear cycle is kept
        bus.icrs = 1'b1; bus.wr = 1'b0;
        cycle();
        bus.icrs = 1'b0;
        ser = 1'b1; cycle(); ser = 1'b0;
        read_clear("ser_race_read", 8'h08);

        // Mask write and event in the same cycle
        bus.icrs = 1'b1; bus.wr = 1'b1; bus.data_in = 8'h81; ta = 1'b1;
        cycle();
        bus.icrs = 1'b0; bus.wr = 1'b0; bus.data_in = 8'h00; ta = 1'b0;
        chk_irq("wr_evt_first", ~DLY);
        cycle();
        chk_irq("wr_evt_irq", 1'b1);

        // Reset in the middle of a read
        bus.icrs = 1'b1; bus.wr = 1'b0;
        cycle();
        reset = 1'b1; bus.icrs = 1'b0;
        cycle();
        reset = 1'b0;
        chk_irq("rst_mid_irq", 1'b0);
        cycle(2);
        read_peek("rst_mid_read", 8'h00);
        tb = 1'b1; cycle(); tb = 1'b0;
        chk_irq("rst_imr_irq", 1'b0);
        cycle();
        chk_irq("rst_imr_irq2", 1'b0);
        read_clear("rst_imr_read", 8'h02);

        if (sb_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_left observed=%0d expected=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
